// File: rtl/coo_row_encoder.sv
// coo_row_encoder: dense row in, serial COO (data,row,col) triplets out.
// Optional COO_EMPTY_ROW_MARKER_EN emits one zero marker per all-zero row.
module coo_row_encoder #(
  parameter int ROW_SIZE   = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [ROW_SIZE-1:0][DATA_WIDTH-1:0] in_data,
  input  logic [ADDR_WIDTH-1:0]               in_row_index,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic [ADDR_WIDTH-1:0]               out_row,
  output logic [ADDR_WIDTH-1:0]               out_col,
  output logic                                out_last,
  output logic                                out_valid,
  input  logic                                out_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EMIT = 2'd1;
`ifdef COO_EMPTY_ROW_MARKER_EN
  localparam logic [1:0] MARK = 2'd2;
`endif

  logic [1:0]                          state;
  logic [1:0]                          state_n;
  logic                                armed;
  logic [ROW_SIZE-1:0]                 mask;
  logic [ROW_SIZE-1:0]                 mask_n;
  logic [ROW_SIZE-1:0]                 nz;
  logic [ROW_SIZE-1:0]                 bsel;
  logic [ROW_SIZE-1:0][DATA_WIDTH-1:0] cap;
  logic [ADDR_WIDTH-1:0]               row_q;
  logic [ADDR_WIDTH-1:0]               sel;
  logic [DATA_WIDTH-1:0]               dsel;
  logic                                cap_en;
  logic                                fire;
  logic                                single;
  logic                                emit;
  logic                                mark;

  always_comb begin
    nz = '0;
    for (int k = 0; k < ROW_SIZE; k++)
      nz[k] = |in_data[k];
  end

  // Descending scan so the lowest set bit is the one left selected.
  always_comb begin
    sel  = '0;
    dsel = '0;
    bsel = '0;
    for (int k = ROW_SIZE - 1; k >= 0; k--) begin
      if (mask[k]) begin
        sel     = ADDR_WIDTH'(k);
        dsel    = cap[k];
        bsel    = '0;
        bsel[k] = 1'b1;
      end
    end
  end

  assign single = (mask != '0) &&
                  ((mask & (mask - ROW_SIZE'(1))) == '0);

  assign emit = (state == EMIT);
`ifdef COO_EMPTY_ROW_MARKER_EN
  assign mark = (state == MARK);
`else
  assign mark = 1'b0;
`endif

  assign in_ready  = armed && (state == IDLE);
  assign out_valid = emit || mark;
  assign cap_en    = in_valid && in_ready;
  assign fire      = out_valid && out_ready;

  assign out_data = emit ? dsel : '0;
  assign out_col  = emit ? sel : '0;
  assign out_row  = out_valid ? row_q : '0;
  assign out_last = (emit && single) || mark;

  always_comb begin
    state_n = state;
    mask_n  = mask;
    unique case (state)
      IDLE: begin
        if (cap_en) begin
          mask_n = nz;
          if (|nz)
            state_n = EMIT;
`ifdef COO_EMPTY_ROW_MARKER_EN
          else
            state_n = MARK;
`endif
        end
      end
      EMIT: begin
        if (fire) begin
          mask_n = mask & ~bsel;
          if (single)
            state_n = IDLE;
        end
      end
`ifdef COO_EMPTY_ROW_MARKER_EN
      MARK: begin
        if (fire)
          state_n = IDLE;
      end
`endif
      default: begin
        state_n = IDLE;
        mask_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      armed <= 1'b0;
      mask  <= '0;
      cap   <= '0;
      row_q <= '0;
    end else begin
      state <= state_n;
      armed <= 1'b1;
      mask  <= mask_n;
      if (cap_en) begin
        cap   <= in_data;
        row_q <= in_row_index;
      end
    end
  end

endmodule

// File: tb/tb_coo_row_encoder.sv
// tb_coo_row_encoder: directed checks of coo_row_encoder.
// Honours COO_EMPTY_ROW_MARKER_EN for the all-zero row case.
module tb_coo_row_encoder;

  logic              clk;
  logic              rst_n;
  logic [3:0][15:0]  in_data;
  logic [15:0]       in_row_index;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       out_data;
  logic [15:0]       out_row;
  logic [15:0]       out_col;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;

  int vecs = 0;
  int errs = 0;

  coo_row_encoder #(
    .ROW_SIZE(4),
    .DATA_WIDTH(16),
    .ADDR_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_row_index(in_row_index),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_row(out_row),
    .out_col(out_col),
    .out_last(out_last),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic trip(input string tag,
                      input logic [15:0] d,
                      input logic [15:0] r,
                      input logic [15:0] c,
                      input logic        l);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".data"},  32'(out_data),  32'(d));
    chk({tag, ".row"},   32'(out_row),   32'(r));
    chk({tag, ".col"},   32'(out_col),   32'(c));
    chk({tag, ".last"},  32'(out_last),  32'(l));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_row(input logic [15:0] r,
                         input logic [15:0] c0,
                         input logic [15:0] c1,
                         input logic [15:0] c2,
                         input logic [15:0] c3);
    in_row_index = r;
    in_data[0]   = c0;
    in_data[1]   = c1;
    in_data[2]   = c2;
    in_data[3]   = c3;
  endtask

  initial begin
    rst_n        = 1'b0;
    in_data      = '0;
    in_row_index = '0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;

    // reset then idle
    repeat (3) step();
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.ready", 32'(in_ready),  32'd0);
    chk("rst.data",  32'(out_data),  32'd0);
    chk("rst.row",   32'(out_row),   32'd0);
    chk("rst.col",   32'(out_col),   32'd0);
    chk("rst.last",  32'(out_last),  32'd0);
    rst_n = 1'b1;
    step();
    chk("idle.ready", 32'(in_ready),  32'd1);
    chk("idle.valid", 32'(out_valid), 32'd0);

    // sparse row 5
    set_row(16'd5, 16'h0000, 16'h0012, 16'h0000, 16'h0034);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("r5.busy", 32'(in_ready), 32'd0);
    trip("r5.t0", 16'h12, 16'd5, 16'd1, 1'b0);
    step();
    trip("r5.t1", 16'h34, 16'd5, 16'd3, 1'b1);
    step();
    chk("r5.done.valid", 32'(out_valid), 32'd0);
    chk("r5.done.ready", 32'(in_ready),  32'd1);

    // full row 2 with stalls
    set_row(16'd2, 16'd1, 16'd2, 16'd3, 16'd4);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      out_ready = 1'b0;
      trip("r2.pre", 16'(i + 1), 16'd2, 16'(i), 1'(i == 3));
      step();
      trip("r2.hold", 16'(i + 1), 16'd2, 16'(i), 1'(i == 3));
      out_ready = 1'b1;
      step();
    end
    chk("r2.done.valid", 32'(out_valid), 32'd0);
    chk("r2.done.ready", 32'(in_ready),  32'd1);

    // all-zero row 7
    set_row(16'd7, 16'd0, 16'd0, 16'd0, 16'd0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
`ifdef COO_EMPTY_ROW_MARKER_EN
    trip("r7.mark", 16'd0, 16'd7, 16'd0, 1'b1);
    chk("r7.busy", 32'(in_ready), 32'd0);
    step();
    chk("r7.done.valid", 32'(out_valid), 32'd0);
`else
    chk("r7.valid", 32'(out_valid), 32'd0);
    chk("r7.ready", 32'(in_ready),  32'd1);
`endif

    // reset mid-row
    set_row(16'd1, 16'd9, 16'd9, 16'd9, 16'd9);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    trip("r1.t0", 16'd9, 16'd1, 16'd0, 1'b0);
    step();
    trip("r1.t1", 16'd9, 16'd1, 16'd1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid.valid", 32'(out_valid), 32'd0);
    chk("mid.ready", 32'(in_ready),  32'd0);
    chk("mid.data",  32'(out_data),  32'd0);
    chk("mid.row",   32'(out_row),   32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("mid.rel.ready", 32'(in_ready), 32'd1);
    set_row(16'd3, 16'd0, 16'd0, 16'd0, 16'd8);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    trip("r3.t0", 16'd8, 16'd3, 16'd3, 1'b1);
    step();
    chk("r3.done.valid", 32'(out_valid), 32'd0);

    // second row held during emit
    set_row(16'd4, 16'd0, 16'd5, 16'd6, 16'd0);
    in_valid = 1'b1;
    step();
    set_row(16'd6, 16'd7, 16'd0, 16'd0, 16'd0);
    chk("r4.busy", 32'(in_ready), 32'd0);
    trip("r4.t0", 16'd5, 16'd4, 16'd1, 1'b0);
    step();
    trip("r4.t1", 16'd6, 16'd4, 16'd2, 1'b1);
    step();
    chk("r4.done.valid", 32'(out_valid), 32'd0);
    chk("r4.done.ready", 32'(in_ready),  32'd1);
    step();
    in_valid = 1'b0;
    trip("r6.t0", 16'd7, 16'd6, 16'd0, 1'b1);
    step();
    chk("r6.done.valid", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
